// File: rtl/adc_front_pkg.sv
// adc_front_pkg: shared types and default sizes for the ADC front-end stage
package adc_front_pkg;

    typedef enum logic [1:0] {ARM, FIRST, TRACK} sd_state_t;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_FILT_LEN    = 4;
    localparam int DEF_PERIOD_W    = 24;

endpackage

// File: rtl/sync_glitch_filter.sv
// sync_glitch_filter: 1-bit synchroniser followed by a run-length deglitch filter
module sync_glitch_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    localparam int CW = $clog2(FILT_LEN + 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]          run_q, run_d;
    logic                   out_q, out_d;
    logic                   synced;

    assign synced = sync_q[SYNC_STAGES-1];
    assign dout   = out_q;

    // shift the async bit in; output flips only after FILT_LEN differing samples in a row
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], din};
        run_d  = '0;
        out_d  = out_q;
        if (synced != out_q) begin
            if (run_q == CW'(FILT_LEN - 1))
                out_d = synced;
            else
                run_d = run_q + 1'b1;
        end
    end

    // state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            run_q  <= '0;
            out_q  <= 1'b0;
        end else begin
            sync_q <= sync_d;
            run_q  <= run_d;
            out_q  <= out_d;
        end
    end

endmodule

// File: rtl/signal_stable_detect.sv
// signal_stable_detect: resynchronise ADC/comparator inputs, measure comparator period, flag frequency lock
module signal_stable_detect
    import adc_front_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int FILT_LEN    = DEF_FILT_LEN,
    parameter int PERIOD_W    = DEF_PERIOD_W,
    parameter int TOL_SHIFT   = 4,
    parameter int STABLE_CNT  = 4,
    parameter int MIN_PERIOD  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [11:0]         adc_data_async,
    input  logic                signal_in_async,
    output logic [11:0]         sync_adc_data,
    output logic                sync_signal_in,
    output logic                stable,
    output logic [PERIOD_W-1:0] period,
    output logic                period_valid
);

    localparam logic [PERIOD_W-1:0] CNT_MAX = '1;

    logic [11:0]         adc_q [SYNC_STAGES];
    logic [11:0]         adc_d [SYNC_STAGES];
    logic                sig, sig_d1_q, sig_d1_d, rise, timeout, valid_len, in_tol;
    logic [PERIOD_W-1:0] cnt_q, cnt_d, prev_q, prev_d, period_q, period_d;
    logic [PERIOD_W:0]   diff;
    logic [3:0]          match_q, match_d;
    logic                pv_q, pv_d, stable_q, stable_d;
    sd_state_t           state_q, state_d;

    sync_glitch_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILT_LEN    (FILT_LEN)
    ) u_cmp_filt (
        .clk  (clk),
        .rst  (rst),
        .din  (signal_in_async),
        .dout (sig)
    );

    assign sync_adc_data  = adc_q[SYNC_STAGES-1];
    assign sync_signal_in = sig;
    assign stable         = stable_q;
    assign period         = period_q;
    assign period_valid   = pv_q;

    // plain multi-flop synchroniser for the ADC bus
    always_comb begin
        adc_d[0] = adc_data_async;
        for (int i = 1; i < SYNC_STAGES; i++)
            adc_d[i] = adc_q[i-1];
    end

    // edge detect, period counter, ARM/FIRST/TRACK tracking and match counting
    always_comb begin
        rise      = sig & ~sig_d1_q;
        sig_d1_d  = sig;
        timeout   = (state_q != ARM) && (cnt_q == CNT_MAX);
        valid_len = cnt_q >= PERIOD_W'(MIN_PERIOD);
        diff      = (cnt_q >= prev_q) ? {1'b0, cnt_q} - {1'b0, prev_q} : {1'b0, prev_q} - {1'b0, cnt_q};
        in_tol    = diff <= {1'b0, prev_q >> TOL_SHIFT};
        cnt_d     = (rise && !timeout) ? PERIOD_W'(1) : (cnt_q == CNT_MAX ? cnt_q : cnt_q + 1'b1);
        state_d   = state_q;
        prev_d    = prev_q;
        period_d  = period_q;
        pv_d      = 1'b0;
        match_d   = match_q;
        if (timeout) begin
            state_d = ARM;
            match_d = '0;
        end else if (rise) begin
            if (state_q == ARM) begin
                state_d = FIRST;
            end else if (valid_len) begin
                period_d = cnt_q;
                prev_d   = cnt_q;
                pv_d     = 1'b1;
                state_d  = TRACK;
                match_d  = (state_q == FIRST || !in_tol) ? 4'd0 :
                           (match_q == 4'(STABLE_CNT) ? match_q : match_q + 1'b1);
            end else begin
                match_d = '0;
            end
        end
        stable_d = match_q == 4'(STABLE_CNT);
    end

    // state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            adc_q    <= '{default: '0};
            sig_d1_q <= 1'b0;
            cnt_q    <= '0;
            prev_q   <= '0;
            period_q <= '0;
            match_q  <= '0;
            pv_q     <= 1'b0;
            stable_q <= 1'b0;
            state_q  <= ARM;
        end else begin
            adc_q    <= adc_d;
            sig_d1_q <= sig_d1_d;
            cnt_q    <= cnt_d;
            prev_q   <= prev_d;
            period_q <= period_d;
            match_q  <= match_d;
            pv_q     <= pv_d;
            stable_q <= stable_d;
            state_q  <= state_d;
        end
    end

endmodule

// File: tb/tb_signal_stable_detect.sv
// tb_signal_stable_detect: directed scoreboard bench for signal_stable_detect
module tb_signal_stable_detect;
    import adc_front_pkg::*;

    logic        clk = 1'b0, rst = 1'b1;
    logic [11:0] adc = '0;
    logic        sig = 1'b0, sig2 = 1'b0;
    logic [11:0] sync_adc, sync_adc2;
    logic        ssig, ssig2, stable, stable2, pv, pv2;
    logic [23:0] period;
    logic [7:0]  period2;
    int          checks = 0, errors = 0;
    int          q[$], q2[$];
    logic        st_at, st_next, saw;
    logic        pv_prev = 1'b0;

    always #5 clk = ~clk;

    signal_stable_detect dut (
        .clk             (clk),
        .rst             (rst),
        .adc_data_async  (adc),
        .signal_in_async (sig),
        .sync_adc_data   (sync_adc),
        .sync_signal_in  (ssig),
        .stable          (stable),
        .period          (period),
        .period_valid    (pv)
    );

    signal_stable_detect #(.PERIOD_W(8)) dut2 (
        .clk             (clk),
        .rst             (rst),
        .adc_data_async  (adc),
        .signal_in_async (sig2),
        .sync_adc_data   (sync_adc2),
        .sync_signal_in  (ssig2),
        .stable          (stable2),
        .period          (period2),
        .period_valid    (pv2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wave(input int hi, input int lo, input bit two = 1'b0);
        if (two) sig2 = 1'b1; else sig = 1'b1;
        tick(hi);
        if (two) sig2 = 1'b0; else sig = 1'b0;
        tick(lo);
    endtask

    // scoreboard side: every period_valid must match the oldest pushed period
    always @(negedge clk) begin
        if (pv_prev) st_next = stable;
        pv_prev = pv;
        if (pv) begin
            st_at = stable;
            chk("pv_expected", q.size() != 0, 1'b1);
            if (q.size() != 0) chk("period", period, q.pop_front());
        end
        if (pv2) begin
            chk("pv2_expected", q2.size() != 0, 1'b1);
            if (q2.size() != 0) chk("period2", period2, q2.pop_front());
        end
    end

    initial begin
        // reset with toggling inputs
        repeat (5) begin
            @(posedge clk);
            #1;
            adc = 12'($urandom);
            sig = ~sig;
            chk("rst_adc", sync_adc, 0);
            chk("rst_flags", {ssig, stable, pv}, 0);
            chk("rst_period", period, 0);
        end
        sig = 1'b0;
        adc = '0;
        rst = 1'b0;
        tick(1);
        chk("arm_after_rst", 32'(dut.state_q), 32'(ARM));
        tick(20);
        // lock on period 200
        for (int i = 1; i <= 6; i++) begin
            if (i == 6) chk("stable_before_6", stable, 0);
            if (i > 1) q.push_back(200);
            wave(100, 100);
        end
        chk("st_at_6", st_at, 0);
        chk("st_next_6", st_next, 1);
        // in-tolerance drift then out-of-tolerance jump
        q.push_back(200);
        wave(106, 106);
        q.push_back(212);
        wave(115, 115);
        chk("st_next_212", st_next, 1);
        q.push_back(230);
        wave(100, 100);
        chk("st_at_230", st_at, 1);
        chk("st_next_230", st_next, 0);
        chk("period_230", period, 230);
        // relock
        for (int i = 0; i < 5; i++) begin
            q.push_back(200);
            wave(100, 100);
        end
        chk("relock_1", stable, 1);
        // short glitch in the low phase is swallowed
        q.push_back(200);
        sig = 1'b1;
        tick(100);
        sig = 1'b0;
        tick(40);
        sig = 1'b1;
        tick(2);
        sig = 1'b0;
        saw = 1'b0;
        repeat (12) begin
            tick(1);
            saw |= ssig;
        end
        chk("glitch_blocked", saw, 0);
        tick(46);
        // 5-cycle pulse passes, next rise arrives too early
        q.push_back(200);
        sig = 1'b1;
        saw = 1'b0;
        repeat (5) begin
            tick(1);
            saw |= ssig;
        end
        sig = 1'b0;
        repeat (6) begin
            tick(1);
            saw |= ssig;
        end
        chk("pulse_passes", saw, 1);
        chk("stable_before_short", stable, 1);
        sig = 1'b1;
        tick(15);
        chk("short_clears_stable", stable, 0);
        chk("short_keeps_period", period, 200);
        tick(85);
        sig = 1'b0;
        tick(100);
        for (int i = 0; i < 4; i++) begin
            q.push_back(200);
            wave(100, 100);
        end
        chk("relock_2", stable, 1);
        // ADC bus latency
        adc = 12'hABC;
        tick(1);
        chk("adc_lat_1", sync_adc, 0);
        tick(1);
        chk("adc_lat_2", sync_adc, 12'hABC);
        // reset while locked
        rst = 1'b1;
        tick(1);
        chk("rst_mid_stable", stable, 0);
        chk("rst_mid_state", 32'(dut.state_q), 32'(ARM));
        chk("rst_mid_period", period, 0);
        rst = 1'b0;
        tick(10);
        sig = 1'b1;
        tick(30);
        chk("rearm_first", 32'(dut.state_q), 32'(FIRST));
        sig = 1'b0;
        tick(20);
        // narrow counter: lock at 40 then stop the input
        for (int i = 1; i <= 6; i++) begin
            if (i > 1) q2.push_back(40);
            wave(20, 20, 1'b1);
        end
        chk("w8_locked", stable2, 1);
        tick(300);
        chk("w8_timeout_stable", stable2, 0);
        chk("w8_timeout_state", 32'(dut2.state_q), 32'(ARM));
        chk("w8_cnt_sat", dut2.cnt_q, 8'hFF);
        sig2 = 1'b1;
        tick(30);
        chk("w8_rearm", 32'(dut2.state_q), 32'(FIRST));
        sig2 = 1'b0;
        tick(5);
        chk("q_drained", q.size(), 0);
        chk("q2_drained", q2.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
